imem_program_loader: RTL

//  Writer side of the instruction-memory port: loads a program image into instruction memory.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Assembles big-endian 32-bit instruction words, so the first byte of a word lands in opcode bits [31:24].
//  - Writes each word to consecutive word addresses.
//  - Holds the CPU datapath in reset until the image is fully loaded and its checksum verifies.

---
 rtl/imem_program_loader_if.sv | 22 ++
 rtl/imem_program_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the slave of the byte stream and the source of the memory writes.
interface imem_program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory as big-endian
// 32-bit words, holding the CPU in reset until the image has loaded and its checksum matches.
module imem_program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = (1 << ADDR_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  imem_program_loader_if.slave bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W:0]      words_loaded
);

  localparam int unsigned WL_W  = ADDR_W + 1;
  localparam int unsigned CMP_W = 17;
  localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_e;

  state_e            state_q,      state_d;
  logic [7:0]        len_hi_q,     len_hi_d;
  logic [15:0]       len_q,        len_d;
  logic [23:0]       asm_q,        asm_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [7:0]        csum_q,       csum_d;
  logic [ADDR_W-1:0] addr_cnt_q,   addr_cnt_d;
  logic [WL_W-1:0]   words_q,      words_d;
  logic              in_ready_q,   in_ready_d;
  logic              imem_we_q,    imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q,   cpu_hold_d;
  logic              done_q,       done_d;
  logic              error_q,      error_d;
  logic              xfer_c;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    asm_d        = asm_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    addr_cnt_d   = addr_cnt_q;
    words_d      = words_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    xfer_c       = bus.in_valid && in_ready_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_HI;
          words_d    = '0;
          csum_d     = '0;
          addr_cnt_d = '0;
          byte_cnt_d = '0;
        end
      end
      LEN_HI: begin
        if (xfer_c) begin
          len_hi_d = bus.in_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer_c) begin
          len_d = {len_hi_q, bus.in_data};
          if (len_d == '0)                    state_d = CHECK;
          else if (CMP_W'(len_d) > MAX_LEN)   state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        if (xfer_c) begin
          csum_d     = csum_q ^ bus.in_data;
          asm_d      = {asm_q[15:0], bus.in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes a word: write it on the next cycle
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {asm_q, bus.in_data};
            imem_addr_d  = addr_cnt_q;
            addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
            words_d      = words_q + WL_W'(1);
            if (CMP_W'(words_q) + CMP_W'(1) == CMP_W'(len_q)) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer_c) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 (state_d == DATA)   || (state_d == CHECK);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
    cpu_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      addr_cnt_q   <= '0;
      words_q      <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      addr_cnt_q   <= addr_cnt_d;
      words_q      <= words_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_q;

endmodule
